// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 4;
  localparam int WSEL_W     = 2;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 32 - OFFSET_W - idx_w(sets);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: async read by index/word, sync single-word
// write, tag write that also marks the line valid, and a bulk valid clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int SETS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [idx_w(SETS)-1:0]      rd_idx,
  input  logic [WSEL_W-1:0]           rd_off,
  output logic                        rd_valid,
  output logic [tag_w(SETS)-1:0]      rd_tag,
  output logic [31:0]                 rd_data,
  input  logic                        wr_en,
  input  logic [idx_w(SETS)-1:0]      wr_idx,
  input  logic [WSEL_W-1:0]           wr_off,
  input  logic [31:0]                 wr_data,
  input  logic                        tag_wr,
  input  logic [tag_w(SETS)-1:0]      wr_tag,
  input  logic                        clr_all
);

  localparam int TAG_W = tag_w(SETS);

  logic [31:0]      data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  // Data and tag storage carry no reset; the valid bits guard them.
  always_ff @(posedge i_clk) begin
    if (wr_en) data_q[wr_idx][wr_off] <= wr_data;
    if (tag_wr) tag_q[wr_idx] <= wr_tag;
  end

  // Valid bits: a bulk clear wins over a same-edge line install.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr_all) valid_q <= '0;
    else if (tag_wr) valid_q[wr_idx] <= 1'b1;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a 4-word line refill engine.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | serving hits combinationally; a miss latches the line base
//   REQ   | waiting for backing memory ready to issue word cnt
//   WAIT  | read outstanding; capture returned word into the line
module icache
  import icache_pkg::*;
#(
  parameter int          SETS       = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_ren,
  input  logic [31:0] i_req_addr,
  input  logic        i_inv,
  output logic [31:0] o_res_rdata,
  output logic        o_busy,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS);

  state_t            state;
  logic [WSEL_W-1:0] cnt;
  logic              inv_pending;
  logic [31:0]       miss_addr;
  logic              mem_ren_q;
  logic [31:0]       mem_addr_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_off;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              miss;
  logic              fill_word;
  logic              fill_done;
  logic              clr_all;
  logic              unused_addr_bits;

  assign req_idx = i_req_addr[OFFSET_W +: IDX_W];
  assign req_tag = i_req_addr[31 -: TAG_W];
  assign req_off = i_req_addr[3:2];
  assign unused_addr_bits = ^i_req_addr[1:0];

  assign hit  = i_req_ren & rd_valid & (rd_tag == req_tag);
  assign miss = i_req_ren & ~hit;

  // Returned data only counts while a read is outstanding; a reset in the
  // same cycle suppresses the write so an aborted line never gets data.
  assign fill_word = (state == WAIT) & i_mem_valid & ~i_rst;
  assign fill_done = fill_word & (cnt == WSEL_W'(LINE_WORDS - 1));

  // An invalidate seen during a refill (including its last cycle) must also
  // kill the freshly installed line, so the request re-misses afterwards.
  assign clr_all = ~i_rst & (((state == IDLE) & i_inv) |
                             (fill_done & (inv_pending | i_inv)));

  assign o_busy      = (state != IDLE) | miss;
  assign o_res_rdata = rd_data;
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_addr  = mem_addr_q;

  icache_array #(.SETS(SETS)) u_array (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .rd_idx   (req_idx),
    .rd_off   (req_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_word),
    .wr_idx   (miss_addr[OFFSET_W +: IDX_W]),
    .wr_off   (cnt),
    .wr_data  (i_mem_rdata),
    .tag_wr   (fill_done),
    .wr_tag   (miss_addr[31 -: TAG_W]),
    .clr_all  (clr_all)
  );

  // Refill sequencer with registered memory request outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      inv_pending <= 1'b0;
      miss_addr   <= RESET_ADDR;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
    end else begin
      mem_ren_q <= 1'b0;
      if (i_inv && state != IDLE) inv_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr <= i_req_addr & ~32'hF;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            mem_ren_q  <= 1'b1;
            mem_addr_q <= miss_addr + {28'd0, cnt, 2'b00};
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_valid) begin
            if (cnt == WSEL_W'(LINE_WORDS - 1)) begin
              inv_pending <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the program counter's fetch port and the backing instruction memory. It returns the 32-bit instruction for the fetch address in the same cycle on a hit. On a miss it raises `o_busy` and refills a 4-word line with one outstanding read at a time. It is the responder for the PC's `o_imem_raddr` / `i_inst_busy` pair.

## Interface
- `SETS`, default 32: number of lines; power of two, at least 2. Index width is `IDX_W = log2(SETS)`.
- `RESET_ADDR`, default 32'h00000000: used only as the reset value of the internal miss-address register.
- `i_clk  in  1`: clock.
- `i_rst  in  1`: reset, synchronous, active-high.
- `i_req_ren  in  1`: fetch request valid.
- `i_req_addr  in  32`: byte fetch address; bits [1:0] are ignored.
- `i_inv  in  1`: invalidate all lines (fence.i).
- `o_res_rdata  out  32`: instruction word; meaningful only when `i_req_ren & !o_busy`.
- `o_busy  out  1`: miss or refill in progress; drives the PC's `i_inst_busy`.
- `o_mem_ren  out  1`: backing read request, one-cycle pulse.
- `o_mem_addr  out  32`: word-aligned backing read address.
- `i_mem_ready  in  1`: backing memory can accept a request this cycle.
- `i_mem_valid  in  1`: read data returned this cycle.
- `i_mem_rdata  in  32`: returned word.

## Operation
- Address split:
  - word offset = addr[3:2]
  - index = addr[4+IDX_W-1:4]
  - tag = addr[31:4+IDX_W]
- Hit: `i_req_ren`, the line's valid bit is set, and the stored tag equals the request tag. Hit read is combinational from the arrays.
- FSM states:
  - IDLE: on a request miss, latch the line base address (`addr & ~32'hF`), clear the word counter, go to REQ. `o_busy` is high in the miss cycle itself (combinational).
  - REQ: when `i_mem_ready`, pulse `o_mem_ren` with `o_mem_addr = base + 4*cnt`, go to WAIT.
  - WAIT: on `i_mem_valid`, write `i_mem_rdata` into word `cnt` of the line.
    - If `cnt == 3`: write the tag, set valid, go to IDLE.
    - Otherwise: increment `cnt`, go to REQ.
- `o_busy = (state != IDLE) | (i_req_ren & !hit)`.
- Requests, and changes to `i_req_addr`, are ignored while state is not IDLE. The refill always targets the latched line.
- A refill overwrites the line at its index regardless of the previous tag; no write-back is needed.
- `i_inv` in IDLE clears all valid bits next edge. A same-cycle hit still returns data.
- `i_inv` outside IDLE sets `inv_pending`. On refill completion all valid bits clear, including the new line, and `inv_pending` clears. The next request re-misses.
- `i_mem_valid` seen in IDLE or REQ is ignored.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, all valid bits 0, `inv_pending` 0
  - `o_mem_ren` 0, `o_mem_addr` 0, miss-address register `RESET_ADDR`
  - `o_busy` is 0 only if `i_req_ren` is low.
- Hit latency: 0 cycles (combinational).
- Miss penalty with `i_mem_ready` always high and memory latency L ≥ 1: 1 + 4·(L+1) cycles of `o_busy`. `o_busy` drops the cycle after the final `i_mem_valid`, and the re-presented address then hits.
- `o_mem_ren` and `o_mem_addr` are registered outputs: asserted the cycle after REQ observes `i_mem_ready`.
- `i_mem_valid` in the same cycle as the `o_mem_ren` pulse is legal and must be captured.
- Reset during refill aborts it:
  - state returns to IDLE and valids clear
  - stale `i_mem_valid` responses after reset are ignored
  - the partially written line stays invalid.
- Same-index back-to-back misses for different tags each trigger a full refill (thrash is correct behaviour).

## Structure
- Package `icache_pkg`: state enum (IDLE, REQ, WAIT), `LINE_WORDS = 4`, `OFFSET_W = 4`, and the tag/index width helper functions.
- Sub-module `icache_array`:
  - tag, valid, and data storage (SETS × 4 × 32)
  - async read port, sync single-word write port
  - bulk valid clear
- The FSM, counter, and address latch live in `icache`.

## Test plan
- Cold miss at 0x00000040, memory L=2 with returns 0x11,0x22,0x33,0x44 → `o_mem_addr` sequence 0x40,0x44,0x48,0x4C; `o_busy` high 13 cycles; then a read of 0x48 hits with 0x33.
- Hit after fill: reads of 0x40, 0x44, 0x4C in consecutive cycles → `o_busy` stays 0; data 0x11, 0x22, 0x44.
- Conflict: with SETS=32, a read of 0x240 (same index, new tag) → refill; afterwards 0x40 misses again.
- `i_inv` asserted mid-refill of 0x80 → refill completes, `o_busy` falls; re-read of 0x80 misses and triggers a new refill.
- `i_rst` pulsed during WAIT with a late `i_mem_valid` after reset → no array write; the next read of the same address misses.
- `i_mem_ready` low for 5 cycles in REQ → no `o_mem_ren` pulse; `o_busy` held high; the request issues on the first ready cycle.
